// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output peripheral: widths, channel modes
// and the duty-compare helper used by the channel mux.
package pwm_pkg;

    localparam int DUTY_W    = 8;
    localparam int PWM_STEPS = 256;
    localparam int NUM_CH    = 16;

    localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;
    // Last value of the PWM counter before it wraps back to zero.
    localparam logic [DUTY_W-1:0] CNT_LAST  = DUTY_W'(PWM_STEPS - 1);

    typedef enum logic [1:0] {
        CH_OFF = 2'd0,
        CH_ON  = 2'd1,
        CH_PWM = 2'd2
    } ch_mode_e;

    // Decode the two enable bits of one channel into its operating mode.
    function automatic ch_mode_e ch_mode(input logic en_out, input logic en_pwm);
        ch_mode_e mode;
        if (!en_out) begin
            mode = CH_OFF;
        end else if (en_pwm) begin
            mode = CH_PWM;
        end else begin
            mode = CH_ON;
        end
        return mode;
    endfunction

    // Full-scale duty forces a constant high; otherwise high while cnt < duty.
    function automatic logic pwm_compare(input logic [DUTY_W-1:0] cnt,
                                         input logic [DUTY_W-1:0] duty);
        logic level;
        if (duty == DUTY_FULL) begin
            level = 1'b1;
        end else begin
            level = (cnt < duty);
        end
        return level;
    endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// Register-side and pin-side signals of the PWM peripheral. The master is
// the register file that owns the enables and duty; the slave is the PWM.
interface pwm_peripheral_if;
    import pwm_pkg::*;

    logic [7:0]        en_reg_out_7_0;
    logic [7:0]        en_reg_out_15_8;
    logic [7:0]        en_reg_pwm_7_0;
    logic [7:0]        en_reg_pwm_15_8;
    logic [DUTY_W-1:0] pwm_duty_cycle;
    logic [NUM_CH-1:0] out;
    logic              period_start;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  period_start
    );

    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output period_start
    );

endinterface

// File: rtl/pwm_prescaler.sv
// Divides clk down to the PWM counter tick: one tick every PRESCALE cycles,
// the tick being the last count before the prescale counter wraps.
module pwm_prescaler #(
    parameter int PRESCALE = 13
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // A single-state counter still needs one bit to stay a legal vector.
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_pre_cnt;

    // Count 0..PRESCALE-1 and wrap; restart from zero on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt <= '0;
        end else if (r_pre_cnt == LAST) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + CW'(1);
        end
    end

    assign tick = (r_pre_cnt == LAST);

endmodule

// File: rtl/pwm_peripheral.sv
// PWM output peripheral: maps the enable/mode registers and a shared 8-bit
// duty value onto 16 registered output pins driven by one PWM waveform.
// Optional build macro PWM_DUTY_SHADOW_EN: the duty value is only taken at
// the period boundary (and on reset release) so no period is ever partial.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 13
) (
    input  logic           clk,
    input  logic           rst,
    pwm_peripheral_if.slave bus
);

    logic              w_tick;
    logic              w_wrap;
    logic              w_pwm_level;
    logic [NUM_CH-1:0] w_en_out;
    logic [NUM_CH-1:0] w_en_pwm;
    logic [NUM_CH-1:0] w_out_next;

    logic [DUTY_W-1:0] r_pwm_cnt;
    logic [DUTY_W-1:0] r_duty_active;
    logic [NUM_CH-1:0] r_out;
    logic              r_period_start;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_en_out    = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign w_en_pwm    = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    // The edge that takes the counter from its last value back to zero.
    assign w_wrap      = w_tick && (r_pwm_cnt == CNT_LAST);
    assign w_pwm_level = pwm_compare(r_pwm_cnt, r_duty_active);

    // Shared PWM phase counter, advanced once per prescaler tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + DUTY_W'(1);
        end else begin
            r_pwm_cnt <= r_pwm_cnt;
        end
    end

`ifdef PWM_DUTY_SHADOW_EN
    logic r_rst_d;

    // Take a new duty only at the period boundary or on the first cycle out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_active <= '0;
            r_rst_d       <= 1'b1;
        end else begin
            r_rst_d <= 1'b0;
            if (w_wrap || r_rst_d) begin
                r_duty_active <= bus.pwm_duty_cycle;
            end else begin
                r_duty_active <= r_duty_active;
            end
        end
    end
`else
    // Plain registered copy of the duty value; changes apply mid-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_active <= '0;
        end else begin
            r_duty_active <= bus.pwm_duty_cycle;
        end
    end
`endif

    // Per-channel select between low, high and the shared PWM level.
    always_comb begin
        w_out_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (ch_mode(w_en_out[i], w_en_pwm[i]))
                CH_OFF:  w_out_next[i] = 1'b0;
                CH_ON:   w_out_next[i] = 1'b1;
                CH_PWM:  w_out_next[i] = w_pwm_level;
                default: w_out_next[i] = 1'b0;
            endcase
        end
    end

    // Register the pins and the period-start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_out          <= w_out_next;
            r_period_start <= w_wrap;
        end
    end

    assign bus.out          = r_out;
    assign bus.period_start = r_period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: a table of static channel-mode vectors,
// then multi-period waveform runs checked cycle by cycle against a
// closed-form expectation derived from the cycle count since reset release.
module tb_pwm_peripheral;

    localparam int P      = 13;
    localparam int PERIOD = P * 256;
    localparam int NCYC   = 2 * PERIOD + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pwm_peripheral_if u_if ();

    pwm_peripheral #(
        .PRESCALE (P)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [7:0]  duty;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        u_if.en_reg_out_7_0  = eo[7:0];
        u_if.en_reg_out_15_8 = eo[15:8];
        u_if.en_reg_pwm_7_0  = ep[7:0];
        u_if.en_reg_pwm_15_8 = ep[15:8];
        u_if.pwm_duty_cycle  = d;
    endtask

    // Two reset edges with checks; rst is released so the next edge is edge 1.
    task automatic do_reset(input string name);
        rst = 1'b1;
        step();
        check({name, "_rst_out"}, {16'h0, u_if.out}, 32'h0);
        check({name, "_rst_ps"}, {31'h0, u_if.period_start}, 32'h0);
        step();
        check({name, "_rst_out2"}, {16'h0, u_if.out}, 32'h0);
        rst = 1'b0;
    endtask

    // Channel 0 in PWM mode, all others static high. Duty d0 from reset,
    // switched to d1 right after edge change_at (0 = never).
    task automatic run_wave(input logic [7:0] d0, input logic [7:0] d1, input int change_at,
                            input int ncyc, input int exp_hi1, input int exp_hi2,
                            input int probe_k, input int exp_probe, input string name);
        int          wave_err;
        int          ps_err;
        int          ps_cnt;
        int          hi1;
        int          hi2;
        int          new_from;
        int          dj;
        int          cnt;
        logic [7:0]  d_eff;
        logic        lvl;
        logic [15:0] exp_out;
        logic        exp_ps;
        logic        probe_val;
        wave_err  = 0;
        ps_err    = 0;
        ps_cnt    = 0;
        hi1       = 0;
        hi2       = 0;
        probe_val = 1'b0;
`ifdef PWM_DUTY_SHADOW_EN
        new_from = ((change_at / PERIOD) + 1) * PERIOD;
`else
        new_from = change_at + 1;
`endif
        set_inputs(16'hFFFF, 16'h0001, d0);
        do_reset(name);
        for (int k = 1; k <= ncyc; k++) begin
            step();
            dj = k - 1;
            if (dj == 0) begin
                d_eff = 8'h00;
            end else if (change_at > 0 && dj >= new_from) begin
                d_eff = d1;
            end else begin
                d_eff = d0;
            end
            cnt     = (dj / P) % 256;
            lvl     = (d_eff == 8'hFF) || (cnt < int'(d_eff));
            exp_out = {15'h7FFF, lvl};
            exp_ps  = ((k % PERIOD) == 0);
            if (u_if.out !== exp_out) begin
                if (wave_err == 0) begin
                    $display("FAIL %s_first_wave k=%0d: got %0h expected %0h",
                             name, k, u_if.out, exp_out);
                end
                wave_err++;
            end
            if (u_if.period_start !== exp_ps) begin
                ps_err++;
            end
            if (u_if.period_start === 1'b1) begin
                ps_cnt++;
            end
            if (k >= 2 && k <= PERIOD + 1 && u_if.out[0] === 1'b1) begin
                hi1++;
            end
            if (k >= PERIOD + 2 && k <= 2 * PERIOD + 1 && u_if.out[0] === 1'b1) begin
                hi2++;
            end
            if (k == probe_k) begin
                probe_val = u_if.out[0];
            end
            if (k == change_at) begin
                u_if.pwm_duty_cycle = d1;
            end
        end
        check({name, "_wave_mismatches"}, wave_err, 32'd0);
        check({name, "_ps_mismatches"}, ps_err, 32'd0);
        if (exp_hi1 >= 0) begin
            check({name, "_high_period1"}, hi1, exp_hi1);
        end
        if (exp_hi2 >= 0) begin
            check({name, "_high_period2"}, hi2, exp_hi2);
        end
        if (ncyc >= 2 * PERIOD) begin
            check({name, "_ps_count"}, ps_cnt, 32'd2);
        end
        if (probe_k > 0) begin
            check({name, "_probe"}, {31'h0, probe_val}, exp_probe);
        end
    endtask

    initial begin
        // en_out, en_pwm, duty, expected out two edges after reset release
        vecs[0] = '{16'h00FF, 16'h0000, 8'h00, 16'h00FF};
        vecs[1] = '{16'hFFFF, 16'h0001, 8'h80, 16'hFFFF};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 8'h00, 16'h0000};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 8'hFF, 16'hFFFF};
        vecs[4] = '{16'hA5A5, 16'h0F0F, 8'h00, 16'hA0A0};
        vecs[5] = '{16'h0000, 16'hFFFF, 8'hFF, 16'h0000};
        vecs[6] = '{16'hFF00, 16'hF0F0, 8'h00, 16'h0F00};
        vecs[7] = '{16'h1234, 16'h00FF, 8'h40, 16'h1234};

        set_inputs(16'h00FF, 16'h0000, 8'h00);
        for (int v = 0; v < 8; v++) begin
            set_inputs(vecs[v].en_out, vecs[v].en_pwm, vecs[v].duty);
            do_reset($sformatf("vec%0d", v));
            step();
            step();
            check($sformatf("vec%0d_out", v), {16'h0, u_if.out}, {16'h0, vecs[v].exp_out});
        end

        // Static enable changes land on the very next edge.
        set_inputs(16'h3C3C, 16'h0000, 8'h40);
        step();
        check("en_change_3c3c", {16'h0, u_if.out}, 32'h3C3C);
        set_inputs(16'h0000, 16'h0000, 8'h40);
        step();
        check("en_change_off", {16'h0, u_if.out}, 32'h0000);

        run_wave(8'h80, 8'h80, 0, NCYC, 1664, 1664, 0, 0, "duty80");
        run_wave(8'h00, 8'h00, 0, NCYC, 0, 0, 0, 0, "duty00");
        run_wave(8'hFF, 8'hFF, 0, NCYC, PERIOD, PERIOD, 0, 0, "dutyFF");
`ifdef PWM_DUTY_SHADOW_EN
        run_wave(8'h40, 8'hC0, 1000, NCYC, 832, 2496, 1002, 0, "duty40_c0");
`else
        run_wave(8'h40, 8'hC0, 1000, NCYC, 2327, 2496, 1002, 1, "duty40_c0");
`endif
        // Reset in the high phase of a period, then a full realigned run.
        run_wave(8'h80, 8'h80, 0, 500, -1, -1, 500, 1, "mid_pre");
        run_wave(8'h80, 8'h80, 0, NCYC, 1664, 1664, 0, 0, "after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
